// File: rtl/demux10_buf.sv
// demux10_buf: registered 1-to-10 demultiplexer with per-channel holding registers.
// Out-of-range selects are absorbed, counted (saturating) and flagged with err.
module demux10_buf #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         S,
  input  logic               bcast,
  input  logic [WIDTH-1:0]   I,
  output logic [10*WIDTH-1:0] Z,
  output logic [9:0]         z_valid,
  input  logic [9:0]         z_ack,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               err
);

  logic [9:0]  free;
  logic [15:0] free_x;
  logic [15:0] sel_oh;
  logic [9:0]  load;
  logic        accept;
  logic        drop;

  // An acked channel is free this cycle; selects 10-15 read as always free.
  assign free   = ~z_valid | z_ack;
  assign free_x = {6'h3f, free};
  assign sel_oh = 16'd1 << S;

  // Readiness depends only on the target channels, never on in_valid.
  always_comb begin
    in_ready = 1'b1;
    unique case (1'b1)
      bcast:   in_ready = &free;
      default: in_ready = free_x[S];
    endcase
  end

  assign accept = in_valid & in_ready;

  // Decode the accepted word into per-channel load strobes and a drop flag.
  always_comb begin
    load = '0;
    drop = 1'b0;
    if (accept) begin
      unique case (1'b1)
        bcast:         load = 10'h3ff;
        (S <= 4'd9):   load = sel_oh[9:0];
        default:       drop = 1'b1;
      endcase
    end
  end

  // Per-channel holding registers: load beats ack, ack clears valid only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Z       <= '0;
      z_valid <= '0;
    end else begin
      for (int k = 0; k < 10; k++) begin
        if (load[k]) begin
          Z[WIDTH*k +: WIDTH] <= I;
          z_valid[k]          <= 1'b1;
        end else if (z_ack[k] && z_valid[k]) begin
          z_valid[k] <= 1'b0;
        end
      end
    end
  end

  // Saturating drop counter and one-cycle error pulse per drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= drop;
      if (drop && (drop_cnt != {CNT_W{1'b1}}))
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux10_buf.sv
// tb_demux10_buf: directed bench for demux10_buf.
// Inputs change on the falling edge; outputs are sampled there or 1ns later.
module tb_demux10_buf;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  S;
  logic        bcast;
  logic [7:0]  I;
  logic [79:0] Z;
  logic [9:0]  z_valid;
  logic [9:0]  z_ack;
  logic [7:0]  drop_cnt;
  logic        err;

  int errors = 0;
  int checks = 0;

  logic [7:0] vals [10];
  logic [79:0] exp_z;

  demux10_buf #(.WIDTH(8), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .S        (S),
    .bcast    (bcast),
    .I        (I),
    .Z        (Z),
    .z_valid  (z_valid),
    .z_ack    (z_ack),
    .drop_cnt (drop_cnt),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs,
                     input logic [79:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    vals[0] = 8'd1;   vals[1] = 8'd12; vals[2] = 8'd51;
    vals[3] = 8'd47;  vals[4] = 8'd22; vals[5] = 8'd17;
    vals[6] = 8'd83;  vals[7] = 8'd104; vals[8] = 8'd7;
    vals[9] = 8'd21;

    rst_n = 1'b0; in_valid = 1'b0; S = 4'd0;
    bcast = 1'b0; I = 8'd0; z_ack = 10'd0;
    repeat (2) @(negedge clk);
    chk("rst_Z", Z, 80'd0);
    chk("rst_zv", {70'd0, z_valid}, 80'd0);
    chk("rst_cnt", {72'd0, drop_cnt}, 80'd0);
    chk("rst_err", {79'd0, err}, 80'd0);
    rst_n = 1'b1;

    // sequential fill
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; S = k[3:0]; I = vals[k];
      #1 chk("fill_rdy", {79'd0, in_ready}, 80'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("fill_zv", {70'd0, z_valid}, 80'h3ff);
    for (int k = 0; k < 10; k++) begin
      exp_z[8*k +: 8] = vals[k];
      chk("fill_z", {72'd0, Z[8*k +: 8]}, {72'd0, vals[k]});
    end

    // backpressure, then simultaneous ack + load
    in_valid = 1'b1; S = 4'd3; I = 8'd99;
    #1 chk("bp_rdy0", {79'd0, in_ready}, 80'd0);
    @(negedge clk);
    chk("bp_hold", {72'd0, Z[31:24]}, 80'd47);
    z_ack = 10'h008;
    #1 chk("bp_rdy1", {79'd0, in_ready}, 80'd1);
    @(negedge clk);
    z_ack = 10'd0; in_valid = 1'b0;
    chk("bp_z3", {72'd0, Z[31:24]}, 80'd99);
    chk("bp_zv", {70'd0, z_valid}, 80'h3ff);
    exp_z[31:24] = 8'd99;

    // illegal selects
    for (int s = 10; s < 16; s++) begin
      in_valid = 1'b1; S = s[3:0]; I = 8'd5;
      #1 chk("ill_rdy", {79'd0, in_ready}, 80'd1);
      @(negedge clk);
      chk("ill_err", {79'd0, err}, 80'd1);
      chk("ill_cnt", {72'd0, drop_cnt}, 80'(s - 9));
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("ill_errlo", {79'd0, err}, 80'd0);
    chk("ill_cnt6", {72'd0, drop_cnt}, 80'd6);
    chk("ill_Z", Z, exp_z);
    chk("ill_zv", {70'd0, z_valid}, 80'h3ff);

    // drain, then broadcast
    z_ack = 10'h3ff;
    @(negedge clk);
    z_ack = 10'd0;
    chk("drain_zv", {70'd0, z_valid}, 80'd0);
    in_valid = 1'b1; bcast = 1'b1; I = 8'hA5;
    #1 chk("bc_rdy", {79'd0, in_ready}, 80'd1);
    @(negedge clk);
    chk("bc_zv", {70'd0, z_valid}, 80'h3ff);
    chk("bc_Z", Z, {10{8'hA5}});
    I = 8'h5A; z_ack = 10'h1ff;
    #1 chk("bc_rdy0", {79'd0, in_ready}, 80'd0);
    @(negedge clk);
    chk("bc_zv9", {70'd0, z_valid}, 80'h200);
    chk("bc_z9", {72'd0, Z[79:72]}, 80'hA5);
    in_valid = 1'b0; bcast = 1'b0; z_ack = 10'd0;

    // saturation
    in_valid = 1'b1; S = 4'd15;
    repeat (300) @(negedge clk);
    chk("sat_cnt", {72'd0, drop_cnt}, 80'd255);
    chk("sat_err", {79'd0, err}, 80'd1);
    in_valid = 1'b0;

    // reset mid-operation, between edges
    #2 rst_n = 1'b0;
    #1;
    chk("mr_Z", Z, 80'd0);
    chk("mr_zv", {70'd0, z_valid}, 80'd0);
    chk("mr_cnt", {72'd0, drop_cnt}, 80'd0);
    chk("mr_err", {79'd0, err}, 80'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // spurious acks
    z_ack = 10'h3ff;
    for (int s = 0; s < 16; s++) begin
      S = s[3:0];
      #1 chk("sp_rdy", {79'd0, in_ready}, 80'd1);
    end
    bcast = 1'b1;
    #1 chk("sp_rdybc", {79'd0, in_ready}, 80'd1);
    bcast = 1'b0;
    @(negedge clk);
    chk("sp_zv", {70'd0, z_valid}, 80'd0);
    chk("sp_Z", Z, 80'd0);
    chk("sp_cnt", {72'd0, drop_cnt}, 80'd0);
    chk("sp_err", {79'd0, err}, 80'd0);
    z_ack = 10'd0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
